// File: rtl/codma_read_engine.sv
// codma bus read master: walks RD_IDLE/RD_ASK/RD_GRANTED to fetch a run of
// word-aligned beats and buffers them in a first-word-fall-through FIFO.
module codma_read_engine #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic              bus_req_o,
  input  logic              bus_gnt_i,
  output logic              bus_rd_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_err_i,
  output logic              data_valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              data_ready_i,
  output logic              done_o,
  output logic              error_o,
  output logic [1:0]        state_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'b00,
    RD_ASK     = 2'b01,
    RD_GRANTED = 2'b10
  } read_state_t;

  read_state_t        r_state;
  read_state_t        w_next_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_remain;
  logic               r_done;
  logic               r_error;
  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_cmd_go;
  logic w_cmd_zero;
  logic w_rd;
  logic w_err;
  logic w_accept;
  logic w_last;
  logic w_pop;
  logic w_fifo_valid;

  assign w_cmd_go     = (r_state == RD_IDLE) && cmd_valid_i && (cmd_len_i != {LEN_W{1'b0}});
  assign w_cmd_zero   = (r_state == RD_IDLE) && cmd_valid_i && (cmd_len_i == {LEN_W{1'b0}});
  // Strobe gated by the registered count so a same-cycle pop never frees a slot early.
  assign w_rd         = (r_state == RD_GRANTED) && (r_count < CNT_W'(FIFO_DEPTH));
  assign w_err        = (r_state == RD_GRANTED) && bus_err_i && (w_rd || bus_rvalid_i);
  assign w_accept     = w_rd && bus_gnt_i && bus_rvalid_i && !bus_err_i;
  assign w_last       = w_accept && (r_remain == LEN_W'(1));
  assign w_fifo_valid = (r_count != {CNT_W{1'b0}});
  assign w_pop        = w_fifo_valid && data_ready_i;

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= RD_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; error beats acceptance, grant loss falls back to RD_ASK.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RD_IDLE: begin
        if (w_cmd_go) begin
          w_next_state = RD_ASK;
        end else begin
          w_next_state = RD_IDLE;
        end
      end
      RD_ASK: begin
        if (bus_gnt_i) begin
          w_next_state = RD_GRANTED;
        end else begin
          w_next_state = RD_ASK;
        end
      end
      RD_GRANTED: begin
        if (w_err || w_last) begin
          w_next_state = RD_IDLE;
        end else if (!bus_gnt_i) begin
          w_next_state = RD_ASK;
        end else begin
          w_next_state = RD_GRANTED;
        end
      end
      default: w_next_state = RD_IDLE;
    endcase
  end

  // Beat address, remaining count and completion pulses.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_addr   <= {ADDR_W{1'b0}};
      r_remain <= {LEN_W{1'b0}};
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_done  <= w_last || w_cmd_zero;
      r_error <= w_err;
      if (w_cmd_go) begin
        r_addr   <= {cmd_addr_i[ADDR_W-1:2], 2'b00};
        r_remain <= cmd_len_i;
      end else if (w_accept) begin
        r_addr   <= r_addr + ADDR_W'(4);
        r_remain <= r_remain - LEN_W'(1);
      end else begin
        r_addr   <= r_addr;
        r_remain <= r_remain;
      end
    end
  end

  // FIFO pointers and occupancy; an error flushes everything in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else if (w_err) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the count marks them empty.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= bus_rdata_i;
    end
  end

  assign cmd_ready_o  = (r_state == RD_IDLE);
  assign bus_req_o    = (r_state == RD_ASK) || (r_state == RD_GRANTED);
  assign bus_rd_o     = w_rd;
  assign bus_addr_o   = r_addr;
  assign data_valid_o = w_fifo_valid;
  assign data_o       = w_fifo_valid ? r_mem[r_rd_ptr] : {DATA_W{1'b0}};
  assign done_o       = r_done;
  assign error_o      = r_error;
  assign state_o      = r_state;

endmodule

// File: tb/tb_codma_read_engine.sv
// Scoreboard bench for codma_read_engine: directed transfers push expected
// words/addresses into queues; a negedge monitor pops and compares.
module tb_codma_read_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_rd;
  logic [31:0] bus_addr;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        data_valid;
  logic [31:0] data;
  logic        data_ready;
  logic        done;
  logic        error;
  logic [1:0]  state;

  logic [31:0] tb_base;
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int beats = 0;
  int n_done = 0;
  int n_err = 0;
  int n_req = 0;

  always #5 clk = ~clk;

  // Bus model: word index relative to the transfer base, offset by 0xA0.
  assign bus_rdata = 32'hA0 + ((bus_addr - tb_base) >> 2);

  codma_read_engine dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .bus_req_o(bus_req), .bus_gnt_i(bus_gnt), .bus_rd_o(bus_rd),
    .bus_addr_o(bus_addr), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
    .bus_err_i(bus_err), .data_valid_o(data_valid), .data_o(data),
    .data_ready_i(data_ready), .done_o(done), .error_o(error), .state_o(state)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares delivered words and accepted beat addresses against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_word: got %h expected none", data);
        end else begin
          chk("data", data, exp_q.pop_front());
        end
      end
      if (bus_rd && bus_gnt && bus_rvalid && !bus_err) begin
        beats++;
        if (addr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_beat: got addr %h expected none", bus_addr);
        end else begin
          chk("beat_addr", bus_addr, addr_q.pop_front());
        end
      end
      if (done) begin
        n_done++;
        chk("ready_with_done", 32'(cmd_ready), 32'd1);
      end
      if (error) begin
        n_err++;
        chk("flush_on_error", 32'(data_valid), 32'd0);
      end
      if (bus_req) n_req++;
    end
  end

  task automatic chk_rst(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_bus_rd"}, 32'(bus_rd), 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, 32'd0);
    chk({tag, "_data_valid"}, 32'(data_valid), 32'd0);
    chk({tag, "_data"}, data, 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_state"}, 32'(state), 32'd0);
  endtask

  // One transfer: gnt after gnt_wait cycles, ready from ready_off, optional grant
  // drop after drop_at beats for drop_len cycles, optional error on beat err_at.
  task automatic run(input logic [31:0] a, input logic [7:0] len, input int gnt_wait,
                     input int ready_off, input int drop_at, input int drop_len, input int err_at);
    int cyc = 0;
    int drops = 0;
    int d0;
    int e0;
    int nbeats;
    bit fin = 1'b0;
    tb_base = a & 32'hFFFF_FFFC;
    nbeats = (err_at >= 0) ? err_at : int'(len);
    for (int i = 0; i < nbeats; i++) addr_q.push_back(tb_base + 32'(4 * i));
    if (err_at < 0) begin
      for (int i = 0; i < int'(len); i++) exp_q.push_back(32'hA0 + 32'(i));
    end
    d0 = n_done;
    e0 = n_err;
    beats = 0;
    data_ready = (ready_off == 0);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = len;
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_err = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (!fin) begin
      if ((n_done != d0 || n_err != e0) && exp_q.size() == 0 && !data_valid) begin
        fin = 1'b1;
      end else if (cyc >= 400) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout: got %0d cycles expected completion", cyc);
        fin = 1'b1;
      end else begin
        bus_gnt = (cyc >= gnt_wait);
        if (drop_at >= 0 && beats == drop_at && drops < drop_len) begin
          if (drops == 1) chk("state_ask_on_drop", 32'(state), 32'd1);
          bus_gnt = 1'b0;
          drops++;
        end
        bus_err = (err_at >= 0 && beats == err_at && state == 2'd2);
        data_ready = (cyc >= ready_off);
        if (ready_off > 0 && err_at < 0 && cyc == ready_off - 1) begin
          chk("beats_while_full", 32'(beats), 32'd4);
          chk("rd_low_while_full", 32'(bus_rd), 32'd0);
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus_gnt = 1'b0; bus_err = 1'b0; bus_rvalid = 1'b0; data_ready = 1'b1;
    chk("done_count", 32'(n_done - d0), (err_at >= 0) ? 32'd0 : 32'd1);
    chk("error_count", 32'(n_err - e0), (err_at >= 0) ? 32'd1 : 32'd0);
    chk("beat_count", 32'(beats), 32'(nbeats));
    chk("req_dropped", 32'(bus_req), 32'd0);
    chk("state_idle", 32'(state), 32'd0);
    chk("data_pending", 32'(exp_q.size()), 32'd0);
    addr_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int d0;
    int r0;
    int k;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    data_ready = 1'b1; tb_base = 32'd0;
    #12;
    chk_rst("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run(32'h0000_1000, 8'd3, 2, 0, -1, 0, -1);    // basic read
    run(32'h0000_1000, 8'd8, 0, 10, -1, 0, -1);   // back-pressure
    run(32'h0000_1000, 8'd6, 0, 0, 2, 3, -1);     // grant drop
    run(32'h0000_1000, 8'd5, 0, 1000, -1, 0, 2);  // bus error on beat 3

    // Zero-length command completes without touching the bus.
    d0 = n_done; r0 = n_req;
    cmd_valid = 1'b1; cmd_addr = 32'h0000_3000; cmd_len = 8'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_state", 32'(state), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("len0_done_count", 32'(n_done - d0), 32'd1);
    chk("len0_no_req", 32'(n_req - r0), 32'd0);

    run(32'hFFFF_FFFC, 8'd2, 0, 0, -1, 0, -1);    // address wrap
    run(32'h0000_1003, 8'd1, 0, 0, -1, 0, -1);    // low bits ignored

    // Reset during the second beat, then a normal single-word transfer.
    tb_base = 32'h0000_1000;
    for (int i = 0; i < 4; i++) begin
      addr_q.push_back(32'h0000_1000 + 32'(4 * i));
      exp_q.push_back(32'hA0 + 32'(i));
    end
    beats = 0;
    cmd_valid = 1'b1; cmd_addr = 32'h0000_1000; cmd_len = 8'd4;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; data_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    k = 0;
    while (beats < 1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (beats < 1) begin
      n_cmp++; n_bad++;
      $display("FAIL reset_mid_wait: got %0d beats expected 1", beats);
    end
    #2 rst_n = 1'b0;
    #1 chk_rst("reset_mid");
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    addr_q.delete();
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run(32'h0000_2000, 8'd1, 0, 0, -1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
